mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_timeout.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port SPI memory bus arbiter: FSM states,
// port identifiers, the timeout read-data pattern and counter sizing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic        PORT_IF  = 1'b0;
   localparam logic        PORT_D   = 1'b1;
   localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

   // Bits needed to hold 0..limit; a disabled limit still gets one bit.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Saturating BUSY-cycle counter; expired_o marks the last permitted BUSY cycle.
module mem_arb_timeout
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int                CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Counter holds the number of BUSY cycles already completed, so the
   // current cycle is the TIMEOUT_CYCLES-th one when it equals LAST.
   assign expired_o = (TIMEOUT_CYCLES > 0) && enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one SPI memory controller,
// with fixed-priority or round-robin tie break and a BUSY timeout.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_PRIORITY  = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [23:0] if_addr,
   output logic        if_ack,
   input  logic        d_req,
   input  logic [23:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_start,
   output logic [23:0] mem_addr,
   output logic        mem_is_data,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic        mem_done,
   input  logic [31:0] mem_rdata
);

   state_e      state_q;
   logic        last_q;
   logic        win_q;
   logic        grant_d;
   logic        expired;
   logic        if_ack_q, d_ack_q, err_q;
   logic [31:0] rdata_q;
   logic        mem_start_q, mem_is_data_q, mem_we_q;
   logic [23:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   mem_arb_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (state_q != BUSY),
      .enable_i (state_q == BUSY),
      .expired_o(expired)
   );

   // Winner for the current IDLE cycle; a lone requester always wins.
   always_comb begin
      grant_d = PORT_IF;
      if (if_req && d_req) begin
         grant_d = (DATA_PRIORITY != 0) ? PORT_D : ~last_q;
      end else if (d_req) begin
         grant_d = PORT_D;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         last_q        <= PORT_D;
         win_q         <= PORT_IF;
         if_ack_q      <= 1'b0;
         d_ack_q       <= 1'b0;
         err_q         <= 1'b0;
         rdata_q       <= '0;
         mem_start_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_is_data_q <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_wdata_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (if_req || d_req) begin
                  state_q       <= BUSY;
                  win_q         <= grant_d;
                  last_q        <= grant_d;
                  mem_start_q   <= 1'b1;
                  mem_is_data_q <= grant_d;
                  if (grant_d == PORT_D) begin
                     mem_addr_q  <= d_addr;
                     mem_we_q    <= d_we;
                     mem_wdata_q <= d_wdata;
                  end else begin
                     mem_addr_q  <= if_addr;
                     mem_we_q    <= 1'b0;
                     mem_wdata_q <= '0;
                  end
               end
            end
            BUSY: begin
               // A real completion beats a timeout landing in the same cycle.
               if (mem_done || expired) begin
                  state_q       <= DONE;
                  mem_start_q   <= 1'b0;
                  mem_addr_q    <= '0;
                  mem_is_data_q <= 1'b0;
                  mem_we_q      <= 1'b0;
                  mem_wdata_q   <= '0;
                  if_ack_q      <= (win_q == PORT_IF);
                  d_ack_q       <= (win_q == PORT_D);
                  err_q         <= ~mem_done;
                  if (!mem_done) begin
                     rdata_q <= ERR_DATA;
                  end else if (mem_we_q) begin
                     rdata_q <= '0;
                  end else begin
                     rdata_q <= mem_rdata;
                  end
               end
            end
            DONE: begin
               state_q  <= IDLE;
               if_ack_q <= 1'b0;
               d_ack_q  <= 1'b0;
               err_q    <= 1'b0;
               rdata_q  <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign if_ack      = if_ack_q;
   assign d_ack       = d_ack_q;
   assign err         = err_q;
   assign rdata       = rdata_q;
   assign mem_start   = mem_start_q;
   assign mem_addr    = mem_addr_q;
   assign mem_is_data = mem_is_data_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;

endmodule
